// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation search controller.
// The search spans 256 candidates, from -8 to +7 in each axis.
package me_pkg;

  localparam int BLK    = 16;
  localparam int WIN    = 32;
  localparam int NUM_PE = 16;

  localparam logic [12:0] LAST_COUNT = 13'd4111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/me_addr_gen.sv
// Combinational decode of the search counter into memory addresses,
// PE input selects, distance-ready strobes and candidate vectors.
module me_addr_gen
  import me_pkg::*;
(
  input  logic [12:0]       count,
  input  logic              run,
  output logic [7:0]        AddressR,
  output logic [9:0]        AddressS1,
  output logic [9:0]        AddressS2,
  output logic [NUM_PE-1:0] S1S2mux,
  output logic [NUM_PE-1:0] newDist,
  output logic [3:0]        vecX,
  output logic [3:0]        vecY
);

  logic [4:0] v;
  logic [3:0] i;
  logic [3:0] j;
  logic [4:0] row1;
  logic [4:0] row2;
  logic       strobe;

  assign v = count[12:8];
  assign i = count[7:4];
  assign j = count[3:0];

  // row2 feeds PEs still finishing the previous reference row
  always_comb begin
    row1 = v + {1'b0, i};
    if (i == 4'd0)
      row2 = v + 5'd14;
    else
      row2 = v + {1'b0, i} - 5'd1;
  end

  // addresses and per-PE half select
  always_comb begin
    AddressR  = {i, j};
    AddressS1 = {row1, 1'b0, j};
    AddressS2 = {row2, 1'b1, j};
    S1S2mux   = '0;
    for (int k = 0; k < NUM_PE; k++)
      S1S2mux[k] = (j >= 4'(k));
  end

  // PE j finishes a candidate of row v-1 at the start of each reference pass
  always_comb begin
    strobe  = run && (v != 5'd0) && (i == 4'd0);
    newDist = '0;
    vecX    = 4'd0;
    vecY    = 4'd0;
    if (strobe) begin
      newDist = 16'd1 << j;
      vecX    = j - 4'd8;
      vecY    = v[3:0] - 4'd9;
    end
  end

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search sequencer: FSM plus 13-bit cycle counter driving
// the address/strobe decoder for the 16-PE systolic array.
module me_search_ctrl
  import me_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        AddressR,
  output logic [9:0]        AddressS1,
  output logic [9:0]        AddressS2,
  output logic [NUM_PE-1:0] S1S2mux,
  output logic [NUM_PE-1:0] newDist,
  output logic [3:0]        vecX,
  output logic [3:0]        vecY,
  output logic              busy,
  output logic              completed
);

  state_t      state;
  logic [12:0] count;

  // search FSM; count is zero whenever the FSM sits in IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      completed <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!start) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (count == LAST_COUNT) begin
            state     <= DONE;
            busy      <= 1'b0;
            completed <= 1'b1;
          end else begin
            count <= count + 13'd1;
          end
        end
        DONE: begin
          if (!start) begin
            state     <= IDLE;
            count     <= '0;
            completed <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          busy      <= 1'b0;
          completed <= 1'b0;
        end
      endcase
    end
  end

  me_addr_gen u_addr (
    .count     (count),
    .run       (busy),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .S1S2mux   (S1S2mux),
    .newDist   (newDist),
    .vecX      (vecX),
    .vecY      (vecY)
  );

endmodule
